// File: rtl/scaler_vmac.sv
// Vertical-filter MAC engine: per-lane masked tap products, adder tree, then round/clamp/saturate.
// Three pipeline stages share one global advance so valid/ready backpressure stalls everything.
module scaler_vmac #(
  parameter int unsigned PIXEL_BITWIDTH       = 8,
  parameter int unsigned KERNEL_MAX           = 4,
  parameter int unsigned KERNEL_COEF_BITWIDTH = 8,
  parameter int unsigned COEF_FRAC            = 6,
  parameter int unsigned LANES                = 4,
  parameter int unsigned VRLT_BITWIDTH        = 18
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [$clog2(KERNEL_MAX+1)-1:0]            cfg_taps,
  input  logic                                       din_valid,
  output logic                                       din_ready,
  input  logic [KERNEL_COEF_BITWIDTH*KERNEL_MAX-1:0] din_coef,
  input  logic [PIXEL_BITWIDTH*KERNEL_MAX*LANES-1:0] din_pixel,
  input  logic                                       din_last,
  output logic                                       dout_valid,
  input  logic                                       dout_ready,
  output logic [VRLT_BITWIDTH*LANES-1:0]             dout_result,
  output logic [PIXEL_BITWIDTH*LANES-1:0]            dout_pixel,
  output logic [LANES-1:0]                           dout_sat,
  output logic                                       dout_last
);
  localparam int unsigned TapsW = $clog2(KERNEL_MAX + 1);
  localparam int unsigned ProdW = PIXEL_BITWIDTH + 1 + KERNEL_COEF_BITWIDTH;
  localparam int unsigned SumW  = ProdW + $clog2(KERNEL_MAX);
  localparam logic [TapsW-1:0] TapsMax = TapsW'(KERNEL_MAX);
  localparam int RndHalf = 2 ** (COEF_FRAC - 1);
  localparam int PixMax  = 2 ** PIXEL_BITWIDTH - 1;
  localparam int ResHalf = 2 ** (VRLT_BITWIDTH - 1);
  localparam int ResMax  = ResHalf - 1;
  localparam int ResMin  = -ResHalf;

  logic                    w_adv;
  logic [TapsW-1:0]        w_taps;
  logic [KERNEL_MAX-1:0]   w_mask;
  logic signed [ProdW-1:0] w_coef_x [KERNEL_MAX];
  logic signed [ProdW-1:0] w_pix_x  [LANES][KERNEL_MAX];
  logic signed [ProdW-1:0] w_prod   [LANES][KERNEL_MAX];
  logic signed [ProdW-1:0] r_prod   [LANES][KERNEL_MAX];
  logic signed [SumW-1:0]  w_sum    [LANES];
  logic signed [SumW-1:0]  r_sum    [LANES];
  logic signed [31:0]      w_s32    [LANES];
  logic signed [31:0]      w_q32    [LANES];

  logic [VRLT_BITWIDTH*LANES-1:0]  w_result, r_result;
  logic [PIXEL_BITWIDTH*LANES-1:0] w_pixel, r_pixel;
  logic [LANES-1:0]                w_sat, r_sat;
  logic                            r_v1, r_v2, r_v3;
  logic                            r_last1, r_last2, r_last3;

  assign w_adv     = ~r_v3 | dout_ready;
  assign din_ready = w_adv;

  // Zero or out-of-range tap counts select the full kernel.
  always_comb begin
    w_taps = cfg_taps;
    if (cfg_taps == '0 || cfg_taps > TapsMax) w_taps = TapsMax;
    for (int k = 0; k < KERNEL_MAX; k++) w_mask[k] = TapsW'(k) < w_taps;
  end

  always_comb begin
    for (int k = 0; k < KERNEL_MAX; k++) begin
      w_coef_x[k] = ProdW'($signed(din_coef[KERNEL_COEF_BITWIDTH*k +: KERNEL_COEF_BITWIDTH]));
    end
    for (int l = 0; l < LANES; l++) begin
      for (int k = 0; k < KERNEL_MAX; k++) begin
        w_pix_x[l][k] = ProdW'(din_pixel[PIXEL_BITWIDTH*(l*KERNEL_MAX+k) +: PIXEL_BITWIDTH]);
        w_prod[l][k]  = w_mask[k] ? w_pix_x[l][k] * w_coef_x[k] : '0;
      end
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_sum[l] = '0;
      for (int k = 0; k < KERNEL_MAX; k++) w_sum[l] = w_sum[l] + SumW'(r_prod[l][k]);
    end
  end

  // Round half-up with a floor shift, then clamp pixel and saturate raw result independently.
  always_comb begin
    w_result = '0;
    w_pixel  = '0;
    w_sat    = '0;
    for (int l = 0; l < LANES; l++) begin
      w_s32[l] = 32'(r_sum[l]);
      w_q32[l] = (w_s32[l] + RndHalf) >>> COEF_FRAC;
      w_pixel[PIXEL_BITWIDTH*l +: PIXEL_BITWIDTH] = PIXEL_BITWIDTH'(w_q32[l]);
      if (w_q32[l] < 0) begin
        w_pixel[PIXEL_BITWIDTH*l +: PIXEL_BITWIDTH] = '0;
        w_sat[l] = 1'b1;
      end else if (w_q32[l] > PixMax) begin
        w_pixel[PIXEL_BITWIDTH*l +: PIXEL_BITWIDTH] = '1;
        w_sat[l] = 1'b1;
      end
      w_result[VRLT_BITWIDTH*l +: VRLT_BITWIDTH] = VRLT_BITWIDTH'(r_sum[l]);
      if (w_s32[l] > ResMax) begin
        w_result[VRLT_BITWIDTH*l +: VRLT_BITWIDTH] = VRLT_BITWIDTH'(ResMax);
        w_sat[l] = 1'b1;
      end else if (w_s32[l] < ResMin) begin
        w_result[VRLT_BITWIDTH*l +: VRLT_BITWIDTH] = VRLT_BITWIDTH'(ResMin);
        w_sat[l] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      for (int l = 0; l < LANES; l++) begin
        for (int k = 0; k < KERNEL_MAX; k++) r_prod[l][k] <= w_prod[l][k];
        r_sum[l] <= w_sum[l];
      end
      r_last1 <= din_last;
      r_last2 <= r_last1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      r_result <= '0;
      r_pixel  <= '0;
      r_sat    <= '0;
      r_last3  <= 1'b0;
    end else if (w_adv) begin
      r_v1     <= din_valid;
      r_v2     <= r_v1;
      r_v3     <= r_v2;
      r_result <= w_result;
      r_pixel  <= w_pixel;
      r_sat    <= w_sat;
      r_last3  <= r_last2;
    end
  end

  assign dout_valid  = r_v3;
  assign dout_result = r_result;
  assign dout_pixel  = r_pixel;
  assign dout_sat    = r_sat;
  assign dout_last   = r_last3;
endmodule

// File: tb/tb_scaler_vmac.sv
// Self-checking bench for scaler_vmac: directed spec cases plus a randomized stream
// scored against an arithmetic reference model.
module tb_scaler_vmac;
  localparam int P  = 8;
  localparam int K  = 4;
  localparam int C  = 8;
  localparam int F  = 6;
  localparam int L  = 4;
  localparam int V  = 18;
  localparam int TW = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [TW-1:0]    cfg_taps = '0;
  logic             din_valid = 1'b0;
  logic             din_ready;
  logic [C*K-1:0]   din_coef = '0;
  logic [P*K*L-1:0] din_pixel = '0;
  logic             din_last = 1'b0;
  logic             dout_valid;
  logic             dout_ready = 1'b0;
  logic [V*L-1:0]   dout_result;
  logic [P*L-1:0]   dout_pixel;
  logic [L-1:0]     dout_sat;
  logic             dout_last;

  scaler_vmac dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_taps   (cfg_taps),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_coef   (din_coef),
    .din_pixel  (din_pixel),
    .din_last   (din_last),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_result(dout_result),
    .dout_pixel (dout_pixel),
    .dout_sat   (dout_sat),
    .dout_last  (dout_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [V*L-1:0] res;
    logic [P*L-1:0] pix;
    logic [L-1:0]   sat;
    logic           last;
  } exp_t;

  typedef struct packed {
    logic valid;
    logic rdy;
    exp_t d;
  } obs_t;

  typedef struct packed {
    logic [TW-1:0]    taps;
    logic [C*K-1:0]   coef;
    logic [P*K*L-1:0] pix;
    logic             last;
  } beat_t;

  int   n_checks = 0;
  int   n_pass = 0;
  exp_t exp_q[$];

  // Reference: plain integer arithmetic straight from the tap/round/clamp rules.
  function automatic exp_t model(input beat_t b);
    exp_t e;
    int t, s, q, r, d;
    e = '0;
    d = 2 ** F;
    t = (int'(b.taps) == 0 || int'(b.taps) > K) ? K : int'(b.taps);
    for (int l = 0; l < L; l++) begin
      s = 0;
      for (int k = 0; k < t; k++) begin
        s += int'(b.pix[P*(l*K+k) +: P]) * int'($signed(b.coef[C*k +: C]));
      end
      r = s;
      if (r > 2 ** (V - 1) - 1) begin r = 2 ** (V - 1) - 1; e.sat[l] = 1'b1; end
      if (r < -(2 ** (V - 1))) begin r = -(2 ** (V - 1)); e.sat[l] = 1'b1; end
      q = s + d / 2;
      q = (q >= 0) ? q / d : -((-q + d - 1) / d);
      if (q < 0) begin q = 0; e.sat[l] = 1'b1; end
      if (q > 2 ** P - 1) begin q = 2 ** P - 1; e.sat[l] = 1'b1; end
      e.res[V*l +: V] = r[V-1:0];
      e.pix[P*l +: P] = q[P-1:0];
    end
    e.last = b.last;
    return e;
  endfunction

  function automatic beat_t mk(input int t, input int c[K], input int p[K], input bit last);
    beat_t b;
    b.taps = t[TW-1:0];
    b.last = last;
    for (int k = 0; k < K; k++) b.coef[C*k +: C] = c[k][C-1:0];
    for (int l = 0; l < L; l++)
      for (int k = 0; k < K; k++) b.pix[P*(l*K+k) +: P] = p[k][P-1:0];
    return b;
  endfunction

  function automatic beat_t rnd_beat();
    beat_t b;
    b.taps = TW'($urandom_range(0, 7));
    b.last = 1'($urandom_range(0, 1));
    for (int k = 0; k < K; k++) b.coef[C*k +: C] = C'($urandom_range(0, 255));
    for (int i = 0; i < K * L; i++) b.pix[P*i +: P] = P'($urandom_range(0, 255));
    return b;
  endfunction

  task automatic drive(input beat_t b, input bit v);
    cfg_taps  = b.taps;
    din_coef  = b.coef;
    din_pixel = b.pix;
    din_last  = b.last;
    din_valid = v;
  endtask

  // Samples the cycle's state mid-period, then advances to just after the next rising edge.
  task automatic tick(output obs_t o);
    #1;
    o.valid  = dout_valid;
    o.rdy    = din_ready;
    o.d.res  = dout_result;
    o.d.pix  = dout_pixel;
    o.d.sat  = dout_sat;
    o.d.last = dout_last;
    @(posedge clk);
    #1;
  endtask

  task automatic run_single(input beat_t b, output exp_t got, output int lat);
    obs_t o;
    got = '0;
    lat = -1;
    dout_ready = 1'b1;
    drive(b, 1'b1);
    tick(o);
    drive(b, 1'b0);
    if (!o.rdy) lat = -2;
    else begin
      for (int i = 1; i <= 8; i++) begin
        tick(o);
        if (o.valid) begin got = o.d; lat = i; break; end
      end
    end
  endtask

  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0;
    dout_ready = 1'b0;
    #1;
    n_checks++;
    if ({dout_valid, dout_result, dout_pixel, dout_sat, dout_last} !== '0)
      $display("FAIL reset_outputs: got v=%b res=%h pix=%h sat=%b last=%b expected all 0",
               dout_valid, dout_result, dout_pixel, dout_sat, dout_last);
    else n_pass++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(o);
    n_checks++;
    if (o.rdy !== 1'b1 || o.valid !== 1'b0)
      $display("FAIL reset_release: got din_ready=%b dout_valid=%b expected 1/0", o.rdy, o.valid);
    else n_pass++;
  endtask

  task automatic test_basic();
    beat_t b;
    exp_t  got, e;
    int    lat;
    b = mk(4, '{16, 16, 16, 16}, '{100, 100, 100, 100}, 1'b0);
    e = model(b);
    run_single(b, got, lat);
    n_checks++;
    if (lat !== 3) $display("FAIL basic_latency: got %0d expected 3", lat); else n_pass++;
    n_checks++;
    if (got !== e) $display("FAIL basic_model: got %h expected %h", got, e); else n_pass++;
    n_checks++;
    if (got.res[V-1:0] !== 18'd6400 || got.pix[P-1:0] !== 8'd100 || got.sat !== '0)
      $display("FAIL basic_lane0: got res=%0d pix=%0d sat=%b expected 6400/100/0",
               got.res[V-1:0], got.pix[P-1:0], got.sat);
    else n_pass++;
  endtask

  task automatic test_masking();
    beat_t b;
    exp_t  got, e;
    int    lat;
    b = mk(2, '{32, 32, 99, 99}, '{10, 30, 255, 255}, 1'b0);
    e = model(b);
    run_single(b, got, lat);
    n_checks++;
    if (got !== e || got.res[V-1:0] !== 18'd1280 || got.pix[P-1:0] !== 8'd20)
      $display("FAIL mask_t2: got %h expected %h (lane0 1280/20)", got, e);
    else n_pass++;
    b.taps = '0;
    e = model(b);
    run_single(b, got, lat);
    n_checks++;
    if (got !== e || got.pix[P-1:0] !== 8'd255 || got.sat !== 4'hF)
      $display("FAIL mask_t0: got %h expected %h", got, e);
    else n_pass++;
  endtask

  task automatic test_negative();
    beat_t b;
    exp_t  got, e;
    int    lat;
    logic signed [V-1:0] want;
    want = -18'sd8160;
    b = mk(4, '{-16, 48, 48, -16}, '{255, 0, 0, 255}, 1'b0);
    e = model(b);
    run_single(b, got, lat);
    n_checks++;
    if (got !== e || got.res[V-1:0] !== want || got.pix[P-1:0] !== 8'd0 || got.sat !== 4'hF)
      $display("FAIL negative_clamp: got %h expected %h (lane0 res %0d)", got, e, want);
    else n_pass++;
  endtask

  task automatic test_clamp_round();
    beat_t b;
    exp_t  got, e;
    int    lat;
    b = mk(4, '{127, 127, 127, 127}, '{255, 255, 255, 255}, 1'b0);
    e = model(b);
    run_single(b, got, lat);
    n_checks++;
    if (got !== e || got.res[V-1:0] !== 18'd129540 || got.pix[P-1:0] !== 8'd255 || !got.sat[0])
      $display("FAIL clamp_high: got %h expected %h", got, e);
    else n_pass++;
    b = mk(1, '{16, 5, 5, 5}, '{6, 200, 200, 200}, 1'b1);
    e = model(b);
    run_single(b, got, lat);
    n_checks++;
    if (got !== e || got.pix[P-1:0] !== 8'd2 || got.sat !== '0)
      $display("FAIL round_96: got %h expected %h (pix 2)", got, e);
    else n_pass++;
    b = mk(1, '{1, 9, 9, 9}, '{95, 9, 9, 9}, 1'b0);
    e = model(b);
    run_single(b, got, lat);
    n_checks++;
    if (got !== e || got.pix[P-1:0] !== 8'd1)
      $display("FAIL round_95: got %h expected %h (pix 1)", got, e);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    beat_t b;
    obs_t  o, prev;
    exp_t  e;
    int    sent = 0, rcvd = 0, stalls = 0;
    bit    prev_stall = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 60 && rcvd < 8; c++) begin
      dout_ready = !(c >= 5 && c < 10);
      if (sent < 8) begin
        b.taps = 3'd4;
        b.last = (sent == 7);
        for (int k = 0; k < K; k++) b.coef[C*k +: C] = C'(8 + 4 * k + sent);
        for (int i = 0; i < K * L; i++) b.pix[P*i +: P] = P'(sent * 29 + i * 7);
        drive(b, 1'b1);
      end else drive(b, 1'b0);
      tick(o);
      if (sent < 8 && o.rdy) begin exp_q.push_back(model(b)); sent++; end
      if (o.valid && !dout_ready) begin
        stalls++;
        n_checks++;
        if (o.rdy !== 1'b0) $display("FAIL bp_din_ready: got %b expected 0", o.rdy);
        else n_pass++;
      end
      if (prev_stall) begin
        n_checks++;
        if (o.valid !== 1'b1 || o.d !== prev.d)
          $display("FAIL bp_hold: got v=%b %h expected v=1 %h", o.valid, o.d, prev.d);
        else n_pass++;
      end
      if (o.valid && dout_ready) begin
        e = exp_q.pop_front();
        rcvd++;
        n_checks++;
        if (o.d !== e) $display("FAIL bp_result%0d: got %h expected %h", rcvd, o.d, e);
        else n_pass++;
      end
      prev = o;
      prev_stall = o.valid && !dout_ready;
    end
    n_checks++;
    if (rcvd !== 8 || stalls !== 5)
      $display("FAIL bp_counts: got rcvd=%0d stalls=%0d expected 8/5", rcvd, stalls);
    else n_pass++;
  endtask

  task automatic test_random_stream();
    beat_t cur;
    obs_t  o, prev;
    exp_t  e;
    bit    pending = 1'b0, prev_hold = 1'b0;
    int    sent = 0, rcvd = 0;
    exp_q.delete();
    cur = rnd_beat();
    for (int c = 0; c < 2000 && rcvd < 60; c++) begin
      dout_ready = ($urandom_range(0, 3) != 0);
      if (!pending && sent < 60 && $urandom_range(0, 4) != 0) begin
        cur = rnd_beat();
        pending = 1'b1;
      end
      drive(cur, pending);
      tick(o);
      if (pending && o.rdy) begin exp_q.push_back(model(cur)); sent++; pending = 1'b0; end
      if (prev_hold) begin
        n_checks++;
        if (o.valid !== 1'b1 || o.d !== prev.d)
          $display("FAIL rnd_hold: got v=%b %h expected v=1 %h", o.valid, o.d, prev.d);
        else n_pass++;
      end
      if (o.valid && dout_ready) begin
        rcvd++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rnd_extra: got %h expected no output", o.d);
        else begin
          e = exp_q.pop_front();
          if (o.d !== e) $display("FAIL rnd_result%0d: got %h expected %h", rcvd, o.d, e);
          else n_pass++;
        end
      end
      prev = o;
      prev_hold = o.valid && !dout_ready;
    end
    drive(cur, 1'b0);
    n_checks++;
    if (rcvd !== 60 || exp_q.size() !== 0)
      $display("FAIL rnd_count: got %0d left=%0d expected 60/0", rcvd, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    obs_t  o;
    beat_t b;
    exp_t  got, e;
    int    lat;
    dout_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(rnd_beat(), 1'b1);
      tick(o);
    end
    din_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dout_valid, dout_result, dout_pixel, dout_sat, dout_last} !== '0)
      $display("FAIL midreset_outputs: got v=%b res=%h pix=%h expected all 0",
               dout_valid, dout_result, dout_pixel);
    else n_pass++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    b = mk(3, '{20, -7, 33, 90}, '{17, 250, 3, 128}, 1'b1);
    e = model(b);
    run_single(b, got, lat);
    n_checks++;
    if (lat !== 3 || got !== e)
      $display("FAIL midreset_first: got lat=%0d %h expected lat=3 %h", lat, got, e);
    else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_masking();
    test_negative();
    test_clamp_round();
    test_backpressure();
    test_random_stream();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
